// File: rtl/ca_row_renderer.sv
// Elementary cellular-automaton renderer: each cell row on screen is one generation,
// computed serially on the first line of the row and replayed on the remaining lines.
module ca_row_renderer #(
  parameter int          GRID_W    = 100,
  parameter int          LOG_CELL  = 2,
  parameter int          PAD_LEFT  = 120,
  parameter int          V_VISIBLE = 480,
  parameter logic [5:0]  ON_RGB    = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_active,
  input  logic [7:0]  rule,
  input  logic        wrap_en,
  input  logic [1:0]  scroll,
  input  logic        reseed,
  input  logic        rand_mode,
  output logic [5:0]  rgb,
  output logic [15:0] gen_count
);
  localparam int ROWS   = V_VISIBLE >> LOG_CELL;
  localparam int CW     = $clog2(GRID_W);
  localparam int SMAX_I = (ROWS >= 4) ? 3 : ROWS - 1;
  localparam logic [1:0] SCROLL_MAX = SMAX_I[1:0];
  localparam logic [GRID_W-1:0] CENTRE_SEED = {{(GRID_W-1){1'b0}}, 1'b1} << (GRID_W / 2);

  logic [GRID_W-1:0] seed_q, cur_q;
  logic [7:0]        rule_q;
  logic              wrap_q, reseed_q, rand_q, live_q;
  logic [1:0]        scroll_q;
  logic [15:0]       gen_q, lfsr_q;
  logic              left_q, first_q;
  logic [5:0]        rgb_q;

  logic              fs, in_grid, first_line, cell_end, row0, rand_row;
  logic [9:0]        dx, cx, ry;
  logic [CW-1:0]     ci, ci_r;
  logic              nb_left, nb_cen, nb_right, gen_bit, cell_val;
  logic [1:0]        scroll_sat, adv;

  assign fs         = (pix_x == 10'd0) && (pix_y == 10'd0);
  assign dx         = pix_x - 10'(PAD_LEFT);
  assign cx         = dx >> LOG_CELL;
  assign ry         = pix_y >> LOG_CELL;
  assign ci         = cx[CW-1:0];
  assign ci_r       = ci + CW'(1);
  assign in_grid    = live_q && video_active && (pix_x >= 10'(PAD_LEFT))
                      && (cx < 10'(GRID_W)) && (ry < 10'(ROWS));
  assign first_line = (pix_y[LOG_CELL-1:0] == '0);
  assign cell_end   = (dx[LOG_CELL-1:0] == '1);
  assign row0       = (ry == 10'd0);
  assign rand_row   = reseed_q && rand_q && row0 && first_line;

  // Left neighbour comes from a saved copy because cell i-1 was already overwritten;
  // cell 0 of the previous row is kept in first_q for the wrap of the last cell.
  assign nb_cen   = cur_q[ci];
  assign nb_left  = (cx == 10'd0) ? (wrap_q & cur_q[GRID_W-1]) : left_q;
  assign nb_right = (cx == 10'(GRID_W-1)) ? (wrap_q & first_q) : cur_q[ci_r];
  assign gen_bit  = rule_q[{nb_left, nb_cen, nb_right}];
  assign cell_val = rand_row ? lfsr_q[0] : ((first_line && !row0) ? gen_bit : nb_cen);

  assign scroll_sat = (scroll > SCROLL_MAX) ? SCROLL_MAX : scroll;
  assign adv        = (live_q && !reseed_q) ? scroll_q : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q   <= CENTRE_SEED;
      cur_q    <= CENTRE_SEED;
      rule_q   <= 8'd30;
      wrap_q   <= 1'b0;
      scroll_q <= 2'd1;
      reseed_q <= 1'b0;
      rand_q   <= 1'b0;
      live_q   <= 1'b0;
      gen_q    <= 16'd0;
      lfsr_q   <= 16'hACE1;
      left_q   <= 1'b0;
      first_q  <= 1'b0;
      rgb_q    <= 6'd0;
    end else begin
      rgb_q <= (in_grid && cell_val) ? ON_RGB : 6'd0;
      if (fs) begin
        rule_q   <= rule;
        wrap_q   <= wrap_en;
        scroll_q <= scroll_sat;
        reseed_q <= reseed;
        rand_q   <= rand_mode;
        live_q   <= 1'b1;
        gen_q    <= reseed ? 16'd0 : gen_q + {14'd0, adv};
        if (reseed && !rand_mode) begin
          seed_q <= CENTRE_SEED;
          cur_q  <= CENTRE_SEED;
        end else begin
          cur_q  <= seed_q;
        end
      end else if (in_grid && first_line && cell_end) begin
        cur_q[ci] <= cell_val;
        left_q    <= nb_cen;
        if (cx == 10'd0) first_q <= nb_cen;
        if (rand_row) begin
          seed_q[ci] <= cell_val;
          lfsr_q     <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end else if (!reseed_q && (scroll_q != 2'd0) && (ry == {8'd0, scroll_q})) begin
          // This generation becomes the top row of the next frame.
          seed_q[ci] <= cell_val;
        end
      end
    end
  end

  assign rgb       = rgb_q;
  assign gen_count = gen_q;
endmodule

// File: tb/tb_ca_row_renderer.sv
// Frame-level bench for ca_row_renderer: a small VGA-like raster drives the block and a
// reference CA model predicts every pixel; predictions are queued and checked one cycle later.
module tb_ca_row_renderer;
  localparam int GW = 16, LC = 1, PAD = 8, VV = 16, ROWS = 8;
  localparam int H_TOT = 48, H_VIS = 44, V_TOT = 20;
  localparam logic [5:0] ON = 6'b111111;

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] pix_x, pix_y;
  logic video_active, wrap_en, reseed, rand_mode;
  logic [7:0] rule;
  logic [1:0] scroll;
  logic [5:0] rgb;
  logic [15:0] gen_count;

  always #5 clk = ~clk;

  ca_row_renderer #(.GRID_W(GW), .LOG_CELL(LC), .PAD_LEFT(PAD), .V_VISIBLE(VV), .ON_RGB(ON)) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
    .rule(rule), .wrap_en(wrap_en), .scroll(scroll), .reseed(reseed), .rand_mode(rand_mode),
    .rgb(rgb), .gen_count(gen_count));

  typedef struct { logic [5:0] e; int x; int y; } exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0, frame_no = 0;

  logic [GW-1:0] m_seed, m_rows[ROWS], cap[ROWS];
  logic [15:0]   m_seed_gen, m_gen, m_lfsr;
  logic [7:0]    f_rule;
  logic          m_valid;

  function automatic logic [GW-1:0] next_row(input logic [GW-1:0] r, input logic [7:0] rl, input logic wr);
    logic [GW-1:0] n;
    logic l, c, rr;
    for (int i = 0; i < GW; i++) begin
      l  = (i == 0 && !wr) ? 1'b0 : r[(i + GW - 1) % GW];
      c  = r[i];
      rr = (i == GW - 1 && !wr) ? 1'b0 : r[(i + 1) % GW];
      n[i] = rl[{l, c, rr}];
    end
    return n;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic model_reset();
    m_seed = 16'h0100; m_seed_gen = 16'd0; m_gen = 16'd0;
    m_lfsr = 16'hACE1; m_valid = 1'b0; f_rule = 8'd30;
  endtask

  task automatic model_fs();
    f_rule = rule;
    if (reseed) begin
      m_seed_gen = 16'd0;
      if (rand_mode) begin
        for (int i = 0; i < GW; i++) begin
          m_seed[i] = m_lfsr[0];
          m_lfsr = lfsr_next(m_lfsr);
        end
      end else begin
        m_seed = 16'h0100;
      end
    end
    m_gen = m_seed_gen;
    m_rows[0] = m_seed;
    for (int r = 1; r < ROWS; r++) m_rows[r] = next_row(m_rows[r-1], rule, wrap_en);
    if (!reseed && scroll != 2'd0) begin
      m_seed = m_rows[scroll];
      m_seed_gen = m_seed_gen + 16'(scroll);
    end
    m_valid = 1'b1;
    for (int r = 0; r < ROWS; r++) cap[r] = '0;
  endtask

  function automatic logic [5:0] exp_pix(input int x, input int y);
    int cx, ry;
    if (!m_valid || x >= H_VIS || y >= VV || x < PAD) return 6'd0;
    cx = (x - PAD) >> LC;
    ry = y >> LC;
    if (cx >= GW || ry >= ROWS) return 6'd0;
    return m_rows[ry][cx] ? ON : 6'd0;
  endfunction

  task automatic pop_check();
    exp_t t;
    if (sb.size() > 0) begin
      t = sb.pop_front();
      checks++;
      if (rgb !== t.e) $display("FAIL rgb pix(%0d,%0d) got %h want %h", t.x, t.y, rgb, t.e);
      else passes++;
      if (t.x >= PAD && t.x < PAD + GW * 2 && t.y < VV && (t.y % 2) == 0 && ((t.x - PAD) % 2) == 0)
        cap[t.y >> 1][(t.x - PAD) >> 1] = (rgb == ON);
    end
  endtask

  task automatic step_pixel(input int x, input int y);
    @(negedge clk);
    pop_check();
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_active = (x < H_VIS) && (y < VV);
    if (x == 0 && y == 0) model_fs();
    sb.push_back('{exp_pix(x, y), x, y});
  endtask

  task automatic run_frame(input int chg_at, input logic [7:0] chg_rule, input int rst_at);
    int idx;
    for (int y = 0; y < V_TOT; y++) begin
      for (int x = 0; x < H_TOT; x++) begin
        idx = y * H_TOT + x;
        if (idx == rst_at) begin
          @(negedge clk);
          pop_check();
          sb.delete();
          rst_n = 1'b0;
          #1;
          checks++;
          if (rgb !== 6'd0) $display("FAIL async_rst_rgb got %h want 00", rgb); else passes++;
          checks++;
          if (gen_count !== 16'd0) $display("FAIL async_rst_gen got %0d want 0", gen_count); else passes++;
          model_reset();
          @(negedge clk);
          rst_n = 1'b1;
        end else begin
          if (idx == chg_at) rule = chg_rule;
          step_pixel(x, y);
        end
      end
    end
    frame_no++;
    checks++;
    if (gen_count !== m_gen) $display("FAIL gen_count frame %0d got %0d want %0d", frame_no, gen_count, m_gen);
    else passes++;
    $display("frame %0d rule=%0d gen_count=%0d row0=%h row1=%h row2=%h",
             frame_no, f_rule, gen_count, cap[0], cap[1], cap[2]);
  endtask

  task automatic chk_row(input string nm, input logic [GW-1:0] got, input logic [GW-1:0] want);
    checks++;
    if (got !== want) $display("FAIL %s got %h want %h", nm, got, want);
    else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (rgb !== 6'd0) $display("FAIL reset_rgb got %h want 00", rgb); else passes++;
    checks++;
    if (gen_count !== 16'd0) $display("FAIL reset_gen got %0d want 0", gen_count); else passes++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_rule30();
    run_frame(-1, 8'd0, -1);
    chk_row("r30_row0", cap[0], 16'h0100);
    chk_row("r30_row1", cap[1], 16'h0380);
    chk_row("r30_row2", cap[2], 16'h04C0);
  endtask

  task automatic test_rule90();
    rule = 8'd90; reseed = 1'b1;
    run_frame(-1, 8'd0, -1);
    reseed = 1'b0;
    chk_row("r90_row1", cap[1], 16'h0280);
    chk_row("r90_row2", cap[2], 16'h0440);
  endtask

  task automatic test_scroll();
    logic [15:0] want_gen[5];
    want_gen = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3};
    rule = 8'd30; reseed = 1'b1; scroll = 2'd0;
    run_frame(-1, 8'd0, -1);
    reseed = 1'b0; scroll = 2'd1;
    for (int f = 0; f < 5; f++) begin
      if (f == 3) scroll = 2'd0;
      run_frame(-1, 8'd0, -1);
      checks++;
      if (gen_count !== want_gen[f]) $display("FAIL scroll_gen step %0d got %0d want %0d", f, gen_count, want_gen[f]);
      else passes++;
      if (f == 1) chk_row("scroll_top1", cap[0], 16'h0380);
      if (f == 2) chk_row("scroll_top2", cap[0], 16'h04C0);
    end
  endtask

  task automatic test_wrap();
    rule = 8'd170; wrap_en = 1'b0; reseed = 1'b1; scroll = 2'd0;
    run_frame(-1, 8'd0, -1);
    reseed = 1'b0; scroll = 2'd3;
    run_frame(-1, 8'd0, -1);
    run_frame(-1, 8'd0, -1);
    scroll = 2'd2;
    run_frame(-1, 8'd0, -1);
    chk_row("r170_top_cell2", cap[0], 16'h0004);
    scroll = 2'd0; wrap_en = 1'b1;
    run_frame(-1, 8'd0, -1);
    chk_row("r170_wrap_row0", cap[0], 16'h0001);
    chk_row("r170_wrap_row1", cap[1], 16'h8000);
    wrap_en = 1'b0;
    run_frame(-1, 8'd0, -1);
    chk_row("r170_zero_row1", cap[1], 16'h0000);
  endtask

  task automatic test_midframe_rule();
    rule = 8'd30; reseed = 1'b1; scroll = 2'd0;
    run_frame(6 * H_TOT + 20, 8'd110, -1);
    reseed = 1'b0;
    chk_row("mid_keep_r30", cap[2], 16'h04C0);
    run_frame(-1, 8'd0, -1);
    chk_row("mid_new_r110", cap[1], 16'h0180);
  endtask

  task automatic test_reset_midframe();
    rule = 8'd30; reseed = 1'b1; rand_mode = 1'b0; scroll = 2'd0;
    run_frame(-1, 8'd0, 3 * H_TOT + 23);
    reseed = 1'b0;
    run_frame(-1, 8'd0, -1);
    chk_row("post_rst_row1", cap[1], 16'h0380);
    chk_row("post_rst_row2", cap[2], 16'h04C0);
  endtask

  task automatic test_lfsr();
    logic [15:0] s;
    logic [GW-1:0] want;
    s = 16'hACE1;
    for (int i = 0; i < GW; i++) begin
      want[i] = s[0];
      s = lfsr_next(s);
    end
    rule = 8'd30; reseed = 1'b1; rand_mode = 1'b1; scroll = 2'd0;
    run_frame(-1, 8'd0, -1);
    reseed = 1'b0;
    chk_row("lfsr_row0", cap[0], want);
    checks++;
    if (gen_count !== 16'd0) $display("FAIL lfsr_gen got %0d want 0", gen_count); else passes++;
    scroll = 2'd1;
    run_frame(-1, 8'd0, -1);
    chk_row("lfsr_seed_kept", cap[0], want);
    run_frame(-1, 8'd0, -1);
  endtask

  initial begin
    rst_n = 1'b0; pix_x = 10'd5; pix_y = 10'd30; video_active = 1'b0;
    rule = 8'd30; wrap_en = 1'b0; scroll = 2'd0; reseed = 1'b0; rand_mode = 1'b0;
    model_reset();
    test_reset();
    test_rule30();
    test_rule90();
    test_scroll();
    test_wrap();
    test_midframe_rule();
    test_reset_midframe();
    test_lfsr();
    while (sb.size() > 0) begin
      @(negedge clk);
      pop_check();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
